// File: rtl/rom_rd_arbiter.sv
// Shares one single-port, 1-cycle-latency coefficient ROM among N_REQ readers.
// Latency: accept at edge T -> rsp in cycle T+1 (T+2 when RSP_REG_EN is defined).
// Backpressure: one-hot req_ready grant, one accept per cycle; responses cannot stall.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rr_en                 1 = round-robin arbitration, 0 = fixed priority (index 0 highest)
//   req_valid/req_addr    per-requester read requests; requester i addr at [i*AW +: AW]
//   req_ready             one-hot grant, only ever set for a valid requester
//   rsp_valid/rsp_data    one-hot response strobe and shared response word (0 when idle)
//   rom_ren/rom_radd      ROM read port; rom_wout returns the word one cycle later
//
// Build option: define RSP_REG_EN to add an output register stage on rsp_valid/rsp_data.
module rom_rd_arbiter #(
   parameter int N_REQ      = 4,
   parameter int N_ADDR     = 256,
   parameter int DATA_WIDTH = 16,
   localparam int AW        = $clog2(N_ADDR),
   localparam int PW        = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rr_en,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*AW-1:0]   req_addr,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rom_ren,
   output logic [AW-1:0]         rom_radd,
   input  logic [DATA_WIDTH-1:0] rom_wout
);

   logic [PW-1:0]         ptr;
   logic [PW-1:0]         ptr_eff;
   logic [PW-1:0]         idx;
   logic [PW-1:0]         win_idx;
   logic                  found;
   logic [N_REQ-1:0]      grant;
   logic [N_REQ-1:0]      tag_q;
   logic [DATA_WIDTH-1:0] rsp_data_c;

   // A pointer outside 0..N_REQ-1 can only come from a fault; fall back to index 0.
   assign ptr_eff = (int'(ptr) < N_REQ) ? ptr : '0;

   // Search starts at ptr_eff (round-robin) or 0 (fixed) and takes the first valid requester.
   always_comb begin
      grant   = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int o = 0; o < N_REQ; o++) begin
         idx = rr_en ? PW'((int'(ptr_eff) + o) % N_REQ) : PW'(o);
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win_idx    = idx;
         end
      end
      // Nothing may be accepted while reset is held.
      if (!rst_n) begin
         grant = '0;
         found = 1'b0;
      end
   end

   assign req_ready = grant;
   assign rom_ren   = found;
   assign rom_radd  = found ? req_addr[int'(win_idx)*AW +: AW] : '0;

   // ptr moves past the winner; in fixed-priority mode it still tracks so a later switch
   // to round-robin starts from a sensible place.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr   <= '0;
         tag_q <= '0;
      end else begin
         tag_q <= rom_ren ? grant : '0;
         if (rom_ren) begin
            ptr <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
         end
      end
   end

   // Gate the ROM output so the shared bus carries zero when no response is due.
   assign rsp_data_c = (|tag_q) ? rom_wout : '0;

`ifdef RSP_REG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= tag_q;
         rsp_data  <= rsp_data_c;
      end
   end
`else
   assign rsp_valid = tag_q;
   assign rsp_data  = rsp_data_c;
`endif

endmodule
